// File: rtl/i8288_bus_ctrl.sv
// 8288-style bus controller: turns 8088 S2..S0 status into ALE, address latch, commands and
// transceiver controls. Define I8288_ADV_WRITE_EN to assert AMWC_N/AIOWC_N one clock early.
module i8288_bus_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [2:0]        S2_S0,
    input  logic [ADDR_W-1:0] AD_IN,
    output logic              ALE,
    output logic [ADDR_W-1:0] ADDR,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              AMWC_N,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              AIOWC_N,
    output logic              INTA_N,
    output logic              DT_R_N,
    output logic              DEN,
    output logic              BUSY,
    output logic              HALT,
    output logic [3:0]        WAIT_CNT
);

    typedef enum logic [2:0] {ST_IDLE, ST_TS1, ST_TS2, ST_TS3, ST_TS4, ST_HALTED} state_t;
    typedef enum logic [2:0] {CYC_NONE, CYC_INTA, CYC_IOR, CYC_IOW, CYC_MEMR, CYC_MEMW} cyc_t;

    localparam logic [2:0] STS_PASSIVE = 3'b111;
    localparam logic [2:0] STS_HALT    = 3'b011;

    function automatic cyc_t decode_status(input logic [2:0] sts);
        case (sts)
            3'b000:         return CYC_INTA;
            3'b001:         return CYC_IOR;
            3'b010:         return CYC_IOW;
            3'b100, 3'b101: return CYC_MEMR;
            3'b110:         return CYC_MEMW;
            default:        return CYC_NONE;
        endcase
    endfunction

    state_t            state_q, state_d;
    cyc_t              cyc_q, cyc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              ale_q, ale_d;
    logic              memr_n_q, memr_n_d;
    logic              memw_n_q, memw_n_d;
    logic              amwc_n_q, amwc_n_d;
    logic              ior_n_q, ior_n_d;
    logic              iow_n_q, iow_n_d;
    logic              aiowc_n_q, aiowc_n_d;
    logic              inta_n_q, inta_n_d;
    logic              dt_r_n_q, dt_r_n_d;
    logic              den_q, den_d;
    logic              busy_q, busy_d;
    logic              halt_q, halt_d;
    logic              in_cmd, in_ts3, is_read;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cyc_d      = cyc_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_TS4: begin
                if (S2_S0 == STS_HALT) begin
                    state_d = ST_HALTED;
                end else if (S2_S0 != STS_PASSIVE) begin
                    state_d = ST_TS1;
                    cyc_d   = decode_status(S2_S0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TS1: begin
                addr_d     = AD_IN;
                wait_cnt_d = '0;
                state_d    = ST_TS2;
            end
            ST_TS2: state_d = ST_TS3;
            ST_TS3: begin
                if (S2_S0 != STS_PASSIVE) begin
                    if (wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_TS4;
                end
            end
            ST_HALTED: begin
                if (S2_S0 == STS_PASSIVE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered output lines up with its state.
    always_comb begin
        in_cmd   = (state_d == ST_TS2) || (state_d == ST_TS3);
        in_ts3   = (state_d == ST_TS3);
        is_read  = (cyc_d == CYC_INTA) || (cyc_d == CYC_IOR) || (cyc_d == CYC_MEMR);
        ale_d    = (state_d == ST_TS1);
        busy_d   = (state_d == ST_TS1) || in_cmd;
        halt_d   = (state_d == ST_HALTED);
        den_d    = in_cmd;
        dt_r_n_d = !(in_cmd && is_read);
        memr_n_d = !(in_cmd && cyc_d == CYC_MEMR);
        ior_n_d  = !(in_cmd && cyc_d == CYC_IOR);
        inta_n_d = !(in_cmd && cyc_d == CYC_INTA);
        memw_n_d = !(in_ts3 && cyc_d == CYC_MEMW);
        iow_n_d  = !(in_ts3 && cyc_d == CYC_IOW);
`ifdef I8288_ADV_WRITE_EN
        amwc_n_d  = !(in_cmd && cyc_d == CYC_MEMW);
        aiowc_n_d = !(in_cmd && cyc_d == CYC_IOW);
`else
        amwc_n_d  = memw_n_d;
        aiowc_n_d = iow_n_d;
`endif
    end

    // NOTE: state and outputs use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cyc_q      <= CYC_NONE;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            ale_q      <= 1'b0;
            memr_n_q   <= 1'b1;
            memw_n_q   <= 1'b1;
            amwc_n_q   <= 1'b1;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            aiowc_n_q  <= 1'b1;
            inta_n_q   <= 1'b1;
            dt_r_n_q   <= 1'b1;
            den_q      <= 1'b0;
            busy_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            ale_q      <= ale_d;
            memr_n_q   <= memr_n_d;
            memw_n_q   <= memw_n_d;
            amwc_n_q   <= amwc_n_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            aiowc_n_q  <= aiowc_n_d;
            inta_n_q   <= inta_n_d;
            dt_r_n_q   <= dt_r_n_d;
            den_q      <= den_d;
            busy_q     <= busy_d;
            halt_q     <= halt_d;
        end
    end

    assign ALE      = ale_q;
    assign ADDR     = addr_q;
    assign MEMR_N   = memr_n_q;
    assign MEMW_N   = memw_n_q;
    assign AMWC_N   = amwc_n_q;
    assign IOR_N    = ior_n_q;
    assign IOW_N    = iow_n_q;
    assign AIOWC_N  = aiowc_n_q;
    assign INTA_N   = inta_n_q;
    assign DT_R_N   = dt_r_n_q;
    assign DEN      = den_q;
    assign BUSY     = busy_q;
    assign HALT     = halt_q;
    assign WAIT_CNT = wait_cnt_q;

endmodule

// File: tb/tb_i8288_bus_ctrl.sv
// Bench for i8288_bus_ctrl: directed vector table, hand sequences for reset and wait saturation,
// and a random status stream checked against a transaction-level scan model.
module tb_i8288_bus_ctrl;

    typedef struct packed {
        logic        ale;
        logic [19:0] addr;
        logic [6:0]  cmd_n;    // {MEMR, MEMW, AMWC, IOR, IOW, AIOWC, INTA}
        logic        dt_r_n;
        logic        den;
        logic        busy;
        logic        halt;
        logic [3:0]  wait_cnt;
    } out_t;

    typedef struct {
        logic [2:0]  s;
        logic [19:0] ad;
        logic        ale;
        logic [6:0]  act;      // active-high command mask
        logic        dt_r_n;
        logic        den;
        logic        busy;
        logic        halt;
        logic [3:0]  wc;
        logic [19:0] addr;
    } vec_t;

    typedef enum {P_IDLE, P_TS1, P_TS2, P_TS3, P_TS4, P_HALT} phase_t;

    localparam logic [6:0] C_MEMR  = 7'b1000000;
    localparam logic [6:0] C_MEMW  = 7'b0100000;
    localparam logic [6:0] C_AMWC  = 7'b0010000;
    localparam logic [6:0] C_IOR   = 7'b0001000;
    localparam logic [6:0] C_IOW   = 7'b0000100;
    localparam logic [6:0] C_AIOWC = 7'b0000010;
    localparam logic [6:0] C_INTA  = 7'b0000001;
`ifdef I8288_ADV_WRITE_EN
    localparam logic [6:0] AMW2 = C_AMWC;
    localparam logic [6:0] AIO2 = C_AIOWC;
`else
    localparam logic [6:0] AMW2 = 7'b0;
    localparam logic [6:0] AIO2 = 7'b0;
`endif

    localparam int N     = 800;
    localparam int RTAIL = 40;

    logic        CLK;
    logic        RESET_N;
    logic [2:0]  S2_S0;
    logic [19:0] AD_IN;
    logic        ALE, MEMR_N, MEMW_N, AMWC_N, IOR_N, IOW_N, AIOWC_N, INTA_N, DT_R_N, DEN, BUSY, HALT;
    logic [19:0] ADDR;
    logic [3:0]  WAIT_CNT;
    out_t        dut_o;

    int n_pass  = 0;
    int n_total = 0;

    vec_t        vecs[$];
    logic [2:0]  rs[N];
    logic [19:0] rad[N];
    out_t        rexp[N];

    i8288_bus_ctrl #(.ADDR_W(20)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .S2_S0(S2_S0), .AD_IN(AD_IN),
        .ALE(ALE), .ADDR(ADDR), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .AMWC_N(AMWC_N),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .AIOWC_N(AIOWC_N), .INTA_N(INTA_N),
        .DT_R_N(DT_R_N), .DEN(DEN), .BUSY(BUSY), .HALT(HALT), .WAIT_CNT(WAIT_CNT)
    );

    assign dut_o = {ALE, ADDR, MEMR_N, MEMW_N, AMWC_N, IOR_N, IOW_N, AIOWC_N, INTA_N,
                    DT_R_N, DEN, BUSY, HALT, WAIT_CNT};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string fmt(input out_t o);
        return $sformatf("ale=%b addr=%h cmd_n=%b dtr_n=%b den=%b busy=%b halt=%b wait=%0d",
                         o.ale, o.addr, o.cmd_n, o.dt_r_n, o.den, o.busy, o.halt, o.wait_cnt);
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    // Expected pins for a bus phase of a cycle started by status code.
    function automatic out_t mk_out(input phase_t ph, input logic [2:0] code,
                                    input logic [3:0] wc, input logic [19:0] addr);
        out_t o;
        logic [6:0] mask;
        logic active;
        active = (ph == P_TS2) || (ph == P_TS3);
        mask = 7'b0;
        if (active) begin
            case (code)
                3'b000:         mask = C_INTA;
                3'b001:         mask = C_IOR;
                3'b100, 3'b101: mask = C_MEMR;
                3'b010:         mask = (ph == P_TS3) ? (C_IOW | C_AIOWC) : AIO2;
                3'b110:         mask = (ph == P_TS3) ? (C_MEMW | C_AMWC) : AMW2;
                default:        mask = 7'b0;
            endcase
        end
        o.ale      = (ph == P_TS1);
        o.addr     = addr;
        o.cmd_n    = ~mask;
        o.dt_r_n   = !(active && (code == 3'b000 || code == 3'b001 || code == 3'b100 || code == 3'b101));
        o.den      = active;
        o.busy     = (ph == P_TS1) || active;
        o.halt     = (ph == P_HALT);
        o.wait_cnt = wc;
        return o;
    endfunction

    // Scans the status stream cycle by cycle: a cycle spans TS1, TS2, then TS3 until the first
    // passive sample, which yields TS4; idle and TS4 both look at the next sample the same way.
    task automatic run_model();
        int e;
        int p;
        logic [3:0]  wc;
        logic [19:0] addr;
        logic [2:0]  c;
        e = 0;
        wc = 4'd0;
        addr = 20'd0;
        while (e < N) begin
            c = rs[e];
            if (c == 3'b111) begin
                rexp[e] = mk_out(P_IDLE, c, wc, addr);
                e++;
            end else if (c == 3'b011) begin
                p = e;
                while (p < N && (p == e || rs[p] != 3'b111)) begin
                    rexp[p] = mk_out(P_HALT, c, wc, addr);
                    p++;
                end
                if (p < N) rexp[p] = mk_out(P_IDLE, c, wc, addr);
                e = p + 1;
            end else begin
                rexp[e] = mk_out(P_TS1, c, wc, addr);
                if (e + 1 < N) begin
                    addr = rad[e + 1];
                    wc = 4'd0;
                    rexp[e + 1] = mk_out(P_TS2, c, wc, addr);
                end
                if (e + 2 < N) rexp[e + 2] = mk_out(P_TS3, c, wc, addr);
                p = e + 3;
                while (p < N && rs[p] != 3'b111) begin
                    wc = (wc == 4'd15) ? 4'd15 : wc + 4'd1;
                    rexp[p] = mk_out(P_TS3, c, wc, addr);
                    p++;
                end
                if (p < N) rexp[p] = mk_out(P_TS4, c, wc, addr);
                e = p + 1;
            end
        end
    endtask

    task automatic add(input logic [2:0] s, input logic [19:0] ad, input logic ale,
                       input logic [6:0] act, input logic dtr, input logic den, input logic busy,
                       input logic halt, input logic [3:0] wc, input logic [19:0] addr);
        vec_t v;
        v.s = s; v.ad = ad; v.ale = ale; v.act = act; v.dt_r_n = dtr; v.den = den;
        v.busy = busy; v.halt = halt; v.wc = wc; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [2:0] s, input logic [19:0] ad);
        S2_S0 = s;
        AD_IN = ad;
        @(posedge CLK);
        #1;
    endtask

    out_t rst_o;
    out_t e_o;

    initial begin
        // s, ad, ale, act, dt_r_n, den, busy, halt, wc, addr
        // MEMR zero wait
        add(3'b101, 20'hFFFF0, 1, 7'b0,   1, 0, 1, 0, 0, 20'h00000);
        add(3'b101, 20'hFFFF0, 0, C_MEMR, 0, 1, 1, 0, 0, 20'hFFFF0);
        add(3'b111, 20'h00000, 0, C_MEMR, 0, 1, 1, 0, 0, 20'hFFFF0);
        add(3'b111, 20'h00000, 0, 7'b0,   1, 0, 0, 0, 0, 20'hFFFF0);
        add(3'b111, 20'h00000, 0, 7'b0,   1, 0, 0, 0, 0, 20'hFFFF0);
        // IOW with three waits
        add(3'b010, 20'h003D8, 1, 7'b0,            1, 0, 1, 0, 0, 20'hFFFF0);
        add(3'b010, 20'h003D8, 0, AIO2,            1, 1, 1, 0, 0, 20'h003D8);
        add(3'b010, 20'h003D8, 0, C_IOW | C_AIOWC, 1, 1, 1, 0, 0, 20'h003D8);
        add(3'b010, 20'h003D8, 0, C_IOW | C_AIOWC, 1, 1, 1, 0, 1, 20'h003D8);
        add(3'b010, 20'h003D8, 0, C_IOW | C_AIOWC, 1, 1, 1, 0, 2, 20'h003D8);
        add(3'b010, 20'h003D8, 0, C_IOW | C_AIOWC, 1, 1, 1, 0, 3, 20'h003D8);
        add(3'b111, 20'h00000, 0, 7'b0,            1, 0, 0, 0, 3, 20'h003D8);
        add(3'b111, 20'h00000, 0, 7'b0,            1, 0, 0, 0, 3, 20'h003D8);
        // code fetch then MEMW back to back
        add(3'b100, 20'h12345, 1, 7'b0,            1, 0, 1, 0, 3, 20'h003D8);
        add(3'b100, 20'h12345, 0, C_MEMR,          0, 1, 1, 0, 0, 20'h12345);
        add(3'b111, 20'h00000, 0, C_MEMR,          0, 1, 1, 0, 0, 20'h12345);
        add(3'b111, 20'h00000, 0, 7'b0,            1, 0, 0, 0, 0, 20'h12345);
        add(3'b110, 20'h0ABCD, 1, 7'b0,            1, 0, 1, 0, 0, 20'h12345);
        add(3'b110, 20'h0ABCD, 0, AMW2,            1, 1, 1, 0, 0, 20'h0ABCD);
        add(3'b111, 20'h00000, 0, C_MEMW | C_AMWC, 1, 1, 1, 0, 0, 20'h0ABCD);
        add(3'b111, 20'h00000, 0, 7'b0,            1, 0, 0, 0, 0, 20'h0ABCD);
        add(3'b111, 20'h00000, 0, 7'b0,            1, 0, 0, 0, 0, 20'h0ABCD);
        // INTA pair, then halt
        for (int k = 0; k < 2; k++) begin
            add(3'b000, 20'h00008, 1, 7'b0,   1, 0, 1, 0, 0, (k == 0) ? 20'h0ABCD : 20'h00008);
            add(3'b000, 20'h00008, 0, C_INTA, 0, 1, 1, 0, 0, 20'h00008);
            add(3'b111, 20'h00000, 0, C_INTA, 0, 1, 1, 0, 0, 20'h00008);
            add(3'b111, 20'h00000, 0, 7'b0,   1, 0, 0, 0, 0, 20'h00008);
        end
        add(3'b011, 20'h00000, 0, 7'b0, 1, 0, 0, 1, 0, 20'h00008);
        add(3'b011, 20'h00000, 0, 7'b0, 1, 0, 0, 1, 0, 20'h00008);
        add(3'b111, 20'h00000, 0, 7'b0, 1, 0, 0, 0, 0, 20'h00008);
        add(3'b111, 20'h00000, 0, 7'b0, 1, 0, 0, 0, 0, 20'h00008);

        rst_o = mk_out(P_IDLE, 3'b111, 4'd0, 20'd0);

        RESET_N = 1'b0;
        S2_S0 = 3'b111;
        AD_IN = 20'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", dut_o, rst_o);
        #2 RESET_N = 1'b1;
        step(3'b111, 20'd0);
        check("idle_after_reset", dut_o, rst_o);

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].ad);
            e_o.ale = vecs[i].ale;
            e_o.addr = vecs[i].addr;
            e_o.cmd_n = ~vecs[i].act;
            e_o.dt_r_n = vecs[i].dt_r_n;
            e_o.den = vecs[i].den;
            e_o.busy = vecs[i].busy;
            e_o.halt = vecs[i].halt;
            e_o.wait_cnt = vecs[i].wc;
            check($sformatf("vec[%0d]", i), dut_o, e_o);
        end

        // Wait-state saturation over 20 TS3 samples, then hold through idle until the next TS1.
        step(3'b101, 20'hA5A5A);
        check("sat_ts1", dut_o, mk_out(P_TS1, 3'b101, 4'd0, 20'h00008));
        step(3'b101, 20'hA5A5A);
        check("sat_ts2", dut_o, mk_out(P_TS2, 3'b101, 4'd0, 20'hA5A5A));
        step(3'b101, 20'hA5A5A);
        check("sat_ts3", dut_o, mk_out(P_TS3, 3'b101, 4'd0, 20'hA5A5A));
        for (int k = 1; k <= 20; k++) begin
            step(3'b101, 20'hA5A5A);
            check($sformatf("sat_wait%0d", k), dut_o,
                  mk_out(P_TS3, 3'b101, (k > 15) ? 4'd15 : 4'(k), 20'hA5A5A));
        end
        step(3'b111, 20'd0);
        check("sat_ts4", dut_o, mk_out(P_TS4, 3'b101, 4'd15, 20'hA5A5A));
        for (int k = 0; k < 2; k++) begin
            step(3'b111, 20'd0);
            check("sat_idle_hold", dut_o, mk_out(P_IDLE, 3'b111, 4'd15, 20'hA5A5A));
        end
        step(3'b001, 20'h00555);
        check("sat_next_ts1", dut_o, mk_out(P_TS1, 3'b001, 4'd15, 20'hA5A5A));
        step(3'b001, 20'h00555);
        check("sat_cleared", dut_o, mk_out(P_TS2, 3'b001, 4'd0, 20'h00555));
        step(3'b111, 20'd0);
        check("ior_ts3", dut_o, mk_out(P_TS3, 3'b001, 4'd0, 20'h00555));
        step(3'b111, 20'd0);
        step(3'b111, 20'd0);
        check("ior_idle", dut_o, mk_out(P_IDLE, 3'b111, 4'd0, 20'h00555));

        // Reset asserted during TS3 of a MEMW.
        step(3'b110, 20'h0F00F);
        step(3'b110, 20'h0F00F);
        step(3'b110, 20'h0F00F);
        step(3'b110, 20'h0F00F);
        check("memw_before_reset", dut_o, mk_out(P_TS3, 3'b110, 4'd1, 20'h0F00F));
        #2 RESET_N = 1'b0;
        #1 check("reset_async", dut_o, rst_o);
        @(posedge CLK);
        #1 check("reset_held", dut_o, rst_o);
        #2;
        S2_S0 = 3'b111;
        RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(3'b111, 20'd0);
            check($sformatf("post_reset_idle%0d", k), dut_o, rst_o);
        end
        step(3'b101, 20'h11111);
        check("post_reset_fresh", dut_o, mk_out(P_TS1, 3'b101, 4'd0, 20'd0));
        step(3'b101, 20'h11111);
        step(3'b111, 20'd0);
        step(3'b111, 20'd0);
        step(3'b111, 20'd0);

        // Random status stream with alternating quiet and busy stretches.
        for (int i = 0; i < N; i++) begin
            int pct;
            pct = ((i / 50) % 2 == 0) ? 50 : 10;
            if (i >= N - RTAIL) rs[i] = 3'b111;
            else if (int'($urandom_range(0, 99)) < pct) rs[i] = 3'b111;
            else rs[i] = 3'($urandom_range(0, 6));
            rad[i] = 20'($urandom);
        end
        run_model();
        RESET_N = 1'b0;
        #2 RESET_N = 1'b1;
        for (int i = 0; i < N; i++) begin
            step(rs[i], rad[i]);
            check($sformatf("rand[%0d]", i), dut_o, rexp[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
